// File: rtl/cond_pkg.sv
// Shared condition-code encodings, flag bit positions and FSM state type
// for the conditional-execution unit.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_C = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/cond_exec_unit_if.sv
// Issue/flag/predicated-block bundle between the issue stage (master)
// and the conditional-execution unit (slave).
interface cond_exec_unit_if #(parameter int LANES = 2);

   logic             flag_we;
   logic [3:0]       flag_in;
   logic [LANES-1:0] issue_valid;
   logic [4*LANES-1:0] issue_cond;
   logic             it_start;
   logic [3:0]       it_cond;
   logic [2:0]       it_len;
   logic [3:0]       it_then;
   logic             flush;
   logic [LANES-1:0] pass;
   logic [LANES-1:0] pass_valid;
   logic [LANES-1:0] cond_undef;
   logic             it_active;
   logic             it_err;
   logic [3:0]       flags;

   modport master (
      output flag_we, flag_in, issue_valid, issue_cond,
      output it_start, it_cond, it_len, it_then, flush,
      input  pass, pass_valid, cond_undef, it_active, it_err, flags
   );

   modport slave (
      input  flag_we, flag_in, issue_valid, issue_cond,
      input  it_start, it_cond, it_len, it_then, flush,
      output pass, pass_valid, cond_undef, it_active, it_err, flags
   );

endinterface

// File: rtl/cond_eval.sv
// Purely combinational evaluation of one 4-bit condition code against
// a CNVZ flag vector; code 1111 never passes and is flagged as undefined.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass,
   output logic       undef
);

   logic c, n, v, z;

   assign c = flags[FLAG_C];
   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];
   assign z = flags[FLAG_Z];

   always_comb begin
      pass  = 1'b0;
      undef = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c & !z;
         COND_LS: pass = !c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: undef = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_exec_unit.sv
// Multi-lane condition evaluator with flag bypass and an IT-style
// predicated block that overrides lane conditions slot by slot.
module cond_exec_unit
   import cond_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int IT_MAX = 4
) (
   input logic clk,
   input logic rst_n,
   cond_exec_unit_if.slave bus
);

   state_t           state_q, state_d;
   logic [2:0]       remain_q, remain_d;
   logic [3:0]       base_q, base_d;
   logic [3:0]       then_q, then_d;
   logic [3:0]       flags_q;
   logic [3:0]       eff_flags;
   logic [2:0]       used;
   logic             err_d;
   logic             start_bad;
   logic [3:0]       len_mask;
   logic [3:0]       lane_cond [LANES];
   logic [LANES-1:0] lane_pass, lane_undef;
   logic [LANES-1:0] pass_q, pass_valid_q, undef_q;
   logic             it_err_q;

   assign eff_flags = bus.flag_we ? bus.flag_in : flags_q;

   // A block whose base is AL may not contain else slots: AL with bit0
   // inverted would be the undefined code.
   always_comb begin
      len_mask = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         if (s < int'(bus.it_len)) len_mask[s] = 1'b1;
      end
      start_bad = (bus.it_len == 3'd0) || (int'(bus.it_len) > IT_MAX)
                  || !bus.it_then[0] || (bus.it_cond == COND_NV)
                  || ((bus.it_cond == COND_AL) && ((~bus.it_then & len_mask) != 4'b0000));
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      base_d   = base_q;
      then_d   = then_q;
      used     = 3'd0;
      err_d    = 1'b0;
      for (int i = 0; i < LANES; i++) lane_cond[i] = bus.issue_cond[4*i +: 4];
      if (bus.flush) begin
         state_d  = IDLE;
         remain_d = 3'd0;
      end else if (state_q == ACTIVE) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.issue_valid[i] && (used < remain_q)) begin
               lane_cond[i] = then_q[used[1:0]] ? base_q : {base_q[3:1], ~base_q[0]};
               used = used + 3'd1;
            end
         end
         remain_d = remain_q - used;
         then_d   = then_q >> used;
         if (remain_d == 3'd0) state_d = IDLE;
         err_d = bus.it_start;
      end else if (bus.it_start) begin
         if (start_bad) begin
            err_d = 1'b1;
         end else begin
            state_d  = ACTIVE;
            remain_d = bus.it_len;
            base_d   = bus.it_cond;
            then_d   = bus.it_then;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cond_eval u_eval (
         .cond  (lane_cond[g]),
         .flags (eff_flags),
         .pass  (lane_pass[g]),
         .undef (lane_undef[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         remain_q     <= 3'd0;
         base_q       <= 4'd0;
         then_q       <= 4'd0;
         flags_q      <= 4'd0;
         it_err_q     <= 1'b0;
         pass_q       <= '0;
         pass_valid_q <= '0;
         undef_q      <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         base_q   <= base_d;
         then_q   <= then_d;
         it_err_q <= err_d;
         if (bus.flag_we) flags_q <= bus.flag_in;
         pass_valid_q <= bus.flush ? '0 : bus.issue_valid;
         pass_q       <= bus.flush ? '0 : (bus.issue_valid & lane_pass);
         undef_q      <= bus.flush ? '0 : (bus.issue_valid & lane_undef);
      end
   end

   assign bus.pass       = pass_q;
   assign bus.pass_valid = pass_valid_q;
   assign bus.cond_undef = undef_q;
   assign bus.it_active  = (state_q == ACTIVE);
   assign bus.it_err     = it_err_q;
   assign bus.flags      = flags_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_cond_exec_unit;
   import cond_pkg::*;

   localparam int LANES  = 2;
   localparam int IT_MAX = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   bit   cmp_en;

   cond_exec_unit_if #(.LANES(LANES)) bus ();

   cond_exec_unit #(.LANES(LANES), .IT_MAX(IT_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending block slots are a queue of then-bits
   bit               slot_q [$];
   logic [3:0]       m_base;
   logic [3:0]       m_flags;
   logic [LANES-1:0] exp_pass, exp_valid, exp_undef;
   bit               exp_err;
   bit               exp_active;
   logic [3:0]       mf, mc;
   bit               m_was_active;

   function automatic bit cond_true(logic [3:0] code, logic [3:0] f);
      bit r;
      case (code[3:1])
         3'd0: r = f[0];
         3'd1: r = f[3];
         3'd2: r = f[2];
         3'd3: r = f[1];
         3'd4: r = f[3] && !f[0];
         3'd5: r = (f[2] == f[1]);
         3'd6: r = !f[0] && (f[2] == f[1]);
         default: return (code == 4'hE);
      endcase
      return r ^ code[0];
   endfunction

   function automatic bit start_legal(logic [3:0] code, logic [2:0] len, logic [3:0] th);
      if (len == 3'd0 || int'(len) > IT_MAX) return 1'b0;
      if (!th[0] || code == 4'hF) return 1'b0;
      if (code == 4'hE) begin
         for (int s = 0; s < int'(len); s++) if (!th[s]) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q.delete();
         m_base     = 4'd0;
         m_flags    = 4'd0;
         exp_pass   = '0;
         exp_valid  = '0;
         exp_undef  = '0;
         exp_err    = 1'b0;
         exp_active = 1'b0;
      end else begin
         mf           = bus.flag_we ? bus.flag_in : m_flags;
         m_was_active = (slot_q.size() > 0);
         exp_pass     = '0;
         exp_valid    = '0;
         exp_undef    = '0;
         exp_err      = 1'b0;
         if (bus.flush) begin
            slot_q.delete();
         end else begin
            for (int i = 0; i < LANES; i++) begin
               if (bus.issue_valid[i]) begin
                  mc = bus.issue_cond[4*i +: 4];
                  if (slot_q.size() > 0) mc = slot_q.pop_front() ? m_base : (m_base ^ 4'd1);
                  exp_valid[i] = 1'b1;
                  exp_pass[i]  = cond_true(mc, mf);
                  exp_undef[i] = (mc == 4'hF);
               end
            end
            if (bus.it_start) begin
               if (m_was_active || !start_legal(bus.it_cond, bus.it_len, bus.it_then)) begin
                  exp_err = 1'b1;
               end else begin
                  m_base = bus.it_cond;
                  for (int s = 0; s < int'(bus.it_len); s++) slot_q.push_back(bus.it_then[s]);
               end
            end
         end
         if (bus.flag_we) m_flags = bus.flag_in;
         exp_active = (slot_q.size() > 0);
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check_output("m_pass",       32'(bus.pass),       32'(exp_pass));
         check_output("m_pass_valid", 32'(bus.pass_valid), 32'(exp_valid));
         check_output("m_cond_undef", 32'(bus.cond_undef), 32'(exp_undef));
         check_output("m_it_active",  32'(bus.it_active),  32'(exp_active));
         check_output("m_it_err",     32'(bus.it_err),     32'(exp_err));
         check_output("m_flags",      32'(bus.flags),      32'(m_flags));
      end
   end

   task automatic apply_stimulus(input logic fwe, input logic [3:0] fin,
                                 input logic [LANES-1:0] valid, input logic [4*LANES-1:0] conds,
                                 input logic start, input logic [3:0] icond,
                                 input logic [2:0] len, input logic [3:0] th, input logic fl);
      bus.flag_we     = fwe;
      bus.flag_in     = fin;
      bus.issue_valid = valid;
      bus.issue_cond  = conds;
      bus.it_start    = start;
      bus.it_cond     = icond;
      bus.it_len      = len;
      bus.it_then     = th;
      bus.flush       = fl;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] r_then;
      n_checks = 0;
      n_fail   = 0;
      cmp_en   = 1'b0;
      rst_n    = 1'b0;
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 0, 4'h0, 3'd0, 4'h0, 0);
      repeat (2) tick();
      cmp_en = 1'b1;
      check_output("rst_pass_valid", 32'(bus.pass_valid), 32'h0);
      check_output("rst_it_active",  32'(bus.it_active),  32'h0);
      check_output("rst_flags",      32'(bus.flags),      32'h0);
      rst_n = 1'b1;

      // HI passes and LS fails with C=1 Z=0
      apply_stimulus(1, 4'b1000, 2'b00, 8'h00, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      apply_stimulus(0, 4'h0, 2'b11, {COND_LS, COND_HI}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("hi_ls_pass",  32'(bus.pass),       32'h1);
      check_output("hi_ls_valid", 32'(bus.pass_valid), 32'h3);

      // Same-cycle flag write is visible to the lanes
      apply_stimulus(1, 4'b0000, 2'b00, 8'h00, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      apply_stimulus(1, 4'b0001, 2'b01, {COND_AL, COND_EQ}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("bypass_pass",  32'(bus.pass),  32'h1);
      check_output("bypass_flags", 32'(bus.flags), 32'h1);

      // EQ block, len 3, then/else/then, with Z=1
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_EQ, 3'd3, 4'b0101, 0); tick();
      check_output("blk_active0", 32'(bus.it_active), 32'h1);
      apply_stimulus(0, 4'h0, 2'b11, {COND_AL, COND_AL}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("blk_pass1",   32'(bus.pass),      32'h1);
      check_output("blk_active1", 32'(bus.it_active), 32'h1);
      apply_stimulus(0, 4'h0, 2'b01, {COND_AL, COND_NE}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("blk_pass2",   32'(bus.pass),      32'h1);
      check_output("blk_active2", 32'(bus.it_active), 32'h0);

      // Rejected starts
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_EQ, 3'd5, 4'b1111, 0); tick();
      check_output("len5_err",    32'(bus.it_err),    32'h1);
      check_output("len5_active", 32'(bus.it_active), 32'h0);
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("err_pulse", 32'(bus.it_err), 32'h0);
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_EQ, 3'd2, 4'b0110, 0); tick();
      check_output("then0_err", 32'(bus.it_err), 32'h1);
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_EQ, 3'd4, 4'b1111, 0); tick();
      check_output("blk4_active", 32'(bus.it_active), 32'h1);
      check_output("blk4_err",    32'(bus.it_err),    32'h0);
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_NE, 3'd2, 4'b0001, 0); tick();
      check_output("busy_err",    32'(bus.it_err),    32'h1);
      check_output("busy_active", 32'(bus.it_active), 32'h1);

      // Flush during slot 2
      apply_stimulus(0, 4'h0, 2'b01, {COND_AL, COND_NE}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("slot1_pass", 32'(bus.pass), 32'h1);
      apply_stimulus(0, 4'h0, 2'b11, {COND_AL, COND_AL}, 0, 4'h0, 3'd0, 4'h0, 1); tick();
      check_output("flush_valid",  32'(bus.pass_valid), 32'h0);
      check_output("flush_active", 32'(bus.it_active),  32'h0);
      apply_stimulus(0, 4'h0, 2'b01, {COND_AL, COND_NE}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("post_flush_pass",  32'(bus.pass),       32'h0);
      check_output("post_flush_valid", 32'(bus.pass_valid), 32'h1);

      // Undefined code with all flags set
      apply_stimulus(1, 4'b1111, 2'b01, {COND_AL, COND_NV}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("nv_pass",  32'(bus.pass),       32'h0);
      check_output("nv_undef", 32'(bus.cond_undef), 32'h1);

      // Reset in the middle of a block clears everything immediately
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 1, COND_EQ, 3'd4, 4'b1111, 0); tick();
      apply_stimulus(0, 4'h0, 2'b11, {COND_NE, COND_NE}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("pre_rst_pass", 32'(bus.pass), 32'h3);
      apply_stimulus(0, 4'h0, 2'b00, 8'h00, 0, 4'h0, 3'd0, 4'h0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_rst_valid",  32'(bus.pass_valid), 32'h0);
      check_output("async_rst_active", 32'(bus.it_active),  32'h0);
      check_output("async_rst_flags",  32'(bus.flags),      32'h0);
      tick();
      #2 rst_n = 1'b1;
      apply_stimulus(0, 4'h0, 2'b01, {COND_AL, COND_NE}, 0, 4'h0, 3'd0, 4'h0, 0); tick();
      check_output("post_rst_pass",   32'(bus.pass),      32'h1);
      check_output("post_rst_active", 32'(bus.it_active), 32'h0);

      // Randomized traffic, judged by the model only
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            #2 rst_n = 1'b0;
            tick();
            #2 rst_n = 1'b1;
         end
         r_then = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0) r_then[0] = 1'b1;
         apply_stimulus(1'($urandom_range(0, 3) == 0),
                        4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 5) == 0) ? COND_AL : 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, IT_MAX)),
                        r_then,
                        1'($urandom_range(0, 24) == 0));
         tick();
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
